// File: rtl/logic_arbiter_pkg.sv
// Shared constants and types for the logic_arbiter slice: logic op codes,
// arbiter state encoding and datapath width.
package logic_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 2;

    localparam logic [OP_W-1:0] LOGIC_OP_AND = 2'b00;
    localparam logic [OP_W-1:0] LOGIC_OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] LOGIC_OP_XOR = 2'b10;

    localparam logic LOGIC_ARB_IDLE = 1'b0;
    localparam logic LOGIC_ARB_RESP = 1'b1;

    typedef enum logic {
        ARB_IDLE = LOGIC_ARB_IDLE,
        ARB_RESP = LOGIC_ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/logic_arbiter_logic_unit.sv
// Shared combinational logic datapath (AND / OR / XOR); unused op codes give 0.
module logic_unit
    import logic_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            LOGIC_OP_AND: result = a & b;
            LOGIC_OP_OR:  result = a | b;
            LOGIC_OP_XOR: result = a ^ b;
            default:      result = '0;
        endcase
    end

endmodule

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one logic_unit between NUM_REQ requesters with a
// registered, single-entry response. Optional counters via LOGIC_ARBITER_PERF_EN.
module logic_arbiter
    import logic_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [ID_W-1:0]           rsp_id
`ifdef LOGIC_ARBITER_PERF_EN
    ,
    output logic [31:0]               perf_grants,
    output logic [31:0]               perf_stalls
`endif
);

    arb_state_e        state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, owner, winner;
    logic              found, can_grant, grant;
    logic [DATA_W-1:0] mux_a, mux_b, lu_result;
    logic [OP_W-1:0]   mux_op;

    // Returns {found, index} of the first valid requester at or after ptr.
    function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] v,
                                          input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] r;
        int            idx;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (v[idx]) r = {1'b1, ID_W'(idx)};
        end
        return r;
    endfunction

    assign {found, winner} = pick(req_valid, rr_ptr);

    // The response slot frees up in the same cycle the owner consumes it.
    assign can_grant = rstn && ((state == ARB_IDLE) || rsp_ready[owner]);
    assign grant     = can_grant && found;

    assign mux_a  = req_a[DATA_W*winner +: DATA_W];
    assign mux_b  = req_b[DATA_W*winner +: DATA_W];
    assign mux_op = req_op[OP_W*winner +: OP_W];

    logic_unit u_logic_unit (
        .a      (mux_a),
        .b      (mux_b),
        .op     (mux_op),
        .result (lu_result)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (grant)
            state_nxt = ARB_RESP;
        else if (state == ARB_RESP && rsp_ready[owner])
            state_nxt = ARB_IDLE;
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (grant)             req_ready[winner] = 1'b1;
        if (state == ARB_RESP) rsp_valid[owner]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr     <= '0;
            owner      <= '0;
            rsp_result <= '0;
        end else if (grant) begin
            rr_ptr     <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            owner      <= winner;
            rsp_result <= lu_result;
        end
    end

    assign rsp_id = owner;

`ifdef LOGIC_ARBITER_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            if (grant)                   perf_grants <= perf_grants + 32'd1;
            if (|req_valid && !grant)    perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: an abstract round-robin model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_logic_arbiter;
    import logic_arbiter_pkg::*;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*32-1:0]   req_a, req_b;
    logic [N*2-1:0]    req_op;
    logic [31:0]       rsp_result;
    logic [0:0]        rsp_id;
`ifdef LOGIC_ARBITER_PERF_EN
    logic [31:0]       perf_grants, perf_stalls;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic_arbiter #(.NUM_REQ(N), .ID_W(1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id)
`ifdef LOGIC_ARBITER_PERF_EN
        ,
        .perf_grants(perf_grants),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_held;
    int          m_owner, m_ptr;
    logic [31:0] m_result;
    int unsigned m_grants, m_stalls;

    function automatic logic [31:0] op_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == LOGIC_OP_AND) return a & b;
        if (op == LOGIC_OP_OR)  return a | b;
        if (op == LOGIC_OP_XOR) return a ^ b;
        return 32'h0;
    endfunction

    // Requester granted this cycle, or -1.
    function automatic int m_winner();
        if (rstn !== 1'b1) return -1;
        if (m_held && !rsp_ready[m_owner]) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        int w;
        if (!rstn) begin
            m_held   <= 1'b0;
            m_owner  <= 0;
            m_ptr    <= 0;
            m_result <= 32'h0;
            m_grants <= 0;
            m_stalls <= 0;
        end else begin
            w = m_winner();
            if (w >= 0) begin
                m_result <= op_model(req_op[2*w +: 2], req_a[32*w +: 32], req_b[32*w +: 32]);
                m_held   <= 1'b1;
                m_owner  <= w;
                m_ptr    <= (w + 1) % N;
                m_grants <= m_grants + 1;
            end else begin
                if (|req_valid) m_stalls <= m_stalls + 1;
                if (m_held && rsp_ready[m_owner]) m_held <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        int           w;
        logic [N-1:0] e_ready, e_valid;
        w = m_winner();
        e_ready = '0;
        e_valid = '0;
        if (w >= 0) e_ready[w] = 1'b1;
        if (m_held) e_valid[m_owner] = 1'b1;
        chk("model req_ready", 32'(req_ready), 32'(e_ready));
        chk("model rsp_valid", 32'(rsp_valid), 32'(e_valid));
        chk("model rsp_result", rsp_result, m_result);
        chk("model rsp_id", 32'(rsp_id), 32'(m_owner));
`ifdef LOGIC_ARBITER_PERF_EN
        chk("model perf_grants", perf_grants, m_grants);
        chk("model perf_stalls", perf_stalls, m_stalls);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic set(input logic [1:0] v, input logic [1:0] r,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] op0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] op1);
        req_valid = v;
        rsp_ready = r;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_op    = {op1, op0};
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        set(2'b11, 2'b00, 32'hF0F0_00FF, 32'h0FF0_0F0F, LOGIC_OP_AND, 32'h0, 32'h0, LOGIC_OP_OR);
        repeat (2) @(posedge clk);
        #1;
        // 1. reset with all requesters valid
        mid();
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_result", rsp_result, 32'h0);
        nxt();
        rstn = 1'b1;
        mid();
        chk("first grant", 32'(req_ready), 32'h1);
        nxt();
        // 2. single AND op
        set(2'b00, 2'b01, 32'h0, 32'h0, LOGIC_OP_AND, 32'h0, 32'h0, LOGIC_OP_OR);
        mid();
        chk("and rsp_valid", 32'(rsp_valid), 32'h1);
        chk("and rsp_id", 32'(rsp_id), 32'h0);
        chk("and rsp_result", rsp_result, 32'h00F0_000F);
        nxt();
        // 3. round robin, one result per cycle (pointer sits at 1 here)
        set(2'b11, 2'b11, 32'hAAAA_AAAA, 32'h5555_5555, LOGIC_OP_OR,
            32'hAAAA_AAAA, 32'h5555_5555, LOGIC_OP_XOR);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("rr req_ready", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
            if (i > 0) begin
                chk("rr rsp_valid", 32'(rsp_valid), (i % 2 == 1) ? 32'h2 : 32'h1);
                chk("rr rsp_result", rsp_result, 32'hFFFF_FFFF);
            end
            nxt();
        end
        set(2'b00, 2'b11, 32'h0, 32'h0, LOGIC_OP_AND, 32'h0, 32'h0, LOGIC_OP_AND);
        mid();
        chk("rr last rsp_valid", 32'(rsp_valid), 32'h1);
        nxt();
        // 4. backpressure; requester 1 carries the unused op code (5.)
        set(2'b01, 2'b00, 32'h1234_5678, 32'hFFFF_0000, LOGIC_OP_XOR,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
        mid();
        chk("bp grant", 32'(req_ready), 32'h1);
        nxt();
        set(2'b11, 2'b00, 32'h1234_5678, 32'hFFFF_0000, LOGIC_OP_XOR,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp req_ready", 32'(req_ready), 32'h0);
            chk("bp rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp rsp_result", rsp_result, 32'hEDCB_5678);
            nxt();
        end
        rsp_ready = 2'b01;
        mid();
        chk("bp release grant", 32'(req_ready), 32'h2);
        nxt();
        set(2'b00, 2'b10, 32'h0, 32'h0, LOGIC_OP_AND, 32'h0, 32'h0, LOGIC_OP_AND);
        mid();
        chk("badop rsp_valid", 32'(rsp_valid), 32'h2);
        chk("badop rsp_id", 32'(rsp_id), 32'h1);
        chk("badop rsp_result", rsp_result, 32'h0);
        nxt();
        // 6. reset while a result is held
        set(2'b01, 2'b00, 32'h0000_0001, 32'h0000_0003, LOGIC_OP_OR, 32'h0, 32'h0, LOGIC_OP_AND);
        mid();
        chk("pre-reset grant", 32'(req_ready), 32'h1);
        nxt();
        set(2'b00, 2'b00, 32'h0, 32'h0, LOGIC_OP_AND, 32'h0, 32'h0, LOGIC_OP_AND);
        mid();
        chk("pre-reset rsp_valid", 32'(rsp_valid), 32'h1);
        chk("pre-reset rsp_result", rsp_result, 32'h3);
        #2 rstn = 1'b0;
        #1;
        chk("midreset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midreset req_ready", 32'(req_ready), 32'h0);
        chk("midreset rsp_result", rsp_result, 32'h0);
`ifdef LOGIC_ARBITER_PERF_EN
        chk("midreset perf_grants", perf_grants, 32'h0);
`endif
        nxt();
        rstn = 1'b1;
        set(2'b11, 2'b00, 32'h0, 32'h0, LOGIC_OP_AND, 32'h0, 32'h0, LOGIC_OP_AND);
        mid();
        chk("post-reset grant", 32'(req_ready), 32'h1);
        nxt();
        set(2'b00, 2'b11, 32'h0, 32'h0, LOGIC_OP_AND, 32'h0, 32'h0, LOGIC_OP_AND);
        mid();
        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
